// File: rtl/aq_f_spsram_pkg.sv
// Shared types, default sizes and the byte-enable to write-enable expansion
// for the 2048x32 single-port SRAM controller.
package aq_f_spsram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 11;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RSP_DEPTH  = 4;

  // Widest word the expansion helper supports; callers slice down to their width.
  localparam int unsigned WEN_MAX_BYTES  = 64;
  localparam int unsigned WEN_MAX_WIDTH  = WEN_MAX_BYTES * 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Active-high byte enables to active-low per-bit write enables.
  function automatic logic [WEN_MAX_WIDTH-1:0] be_to_wen(input logic [WEN_MAX_BYTES-1:0] be);
    logic [WEN_MAX_WIDTH-1:0] wen;
    wen = '1;
    for (int i = 0; i < int'(WEN_MAX_BYTES); i++) begin
      wen[8*i +: 8] = {8{~be[i]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/aq_f_spsram_rsp_fifo.sv
// Read-response FIFO with a registered head-of-queue output.
module aq_f_spsram_rsp_fifo
  import aq_f_spsram_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RSP_DEPTH,
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remain;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers, occupancy and head word; an empty FIFO forwards the pushed word.
  always_comb begin
    pop_ok   = pop && !empty_q;
    remain   = count_q - CNT_W'(pop_ok);
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = remain + CNT_W'(push);
    dout_d   = dout_q;
    if (remain == '0) begin
      if (push) dout_d = din;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      dout_q   <= dout_d;
    end
  end

  // The credit scheme upstream must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop_ok && (count_q == CNT_W'(DEPTH))));

  assign empty = empty_q;
  assign count = count_q;
  assign dout  = dout_q;

endmodule

// File: rtl/aq_f_spsram_2048x32_ctrl.sv
// Requester-side controller for the 2048x32 single-port SRAM: zero-fill sweep
// after reset, then in-order client reads/byte-masked writes with credit-guarded
// read responses.
module aq_f_spsram_2048x32_ctrl
  import aq_f_spsram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter int unsigned           RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic                      init_done,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_wr,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_WIDTH-1:0]     A,
  output logic                      CEN,
  output logic                      GWEN,
  output logic [DATA_WIDTH-1:0]     WEN,
  output logic [DATA_WIDTH-1:0]     D,
  input  logic [DATA_WIDTH-1:0]     Q
);

  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned CRD_W     = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SWEEP_LEN = 2 ** ADDR_WIDTH;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       addr_cnt_q, addr_cnt_d;
  logic [CRD_W-1:0]       credit_q, credit_d;
  logic                   cen_q, cen_d, gwen_q, gwen_d;
  logic [DATA_WIDTH-1:0]  wen_q, wen_d, d_q, d_d;
  logic [ADDR_WIDTH-1:0]  a_q, a_d;
  logic                   req_rdy_q, req_rdy_d, init_done_q, init_done_d;
  logic                   iss_vld_q, cap_vld_q;
  logic                   req_acc, rd_acc, rsp_pop;
  logic                   fifo_empty;
  logic [CRD_W-1:0]       fifo_count;

  assign req_acc = req_vld && req_rdy_q;
  assign rd_acc  = req_acc && !req_wr;
  assign rsp_pop = !fifo_empty && rsp_rdy;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= INIT_EN ? ST_INIT : ST_RUN;
    else     state_q <= state_d;
  end

  // Next state, next SRAM pin values, credit and handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    cen_d       = 1'b1;
    gwen_d      = 1'b1;
    wen_d       = '1;
    a_d         = a_q;
    d_d         = d_q;
    case (state_q)
      ST_INIT: begin
        if (addr_cnt_q == CNT_W'(SWEEP_LEN)) begin
          state_d = ST_RUN;
        end else begin
          cen_d      = 1'b0;
          gwen_d     = 1'b0;
          wen_d      = '0;
          a_d        = addr_cnt_q[ADDR_WIDTH-1:0];
          d_d        = INIT_VAL;
          addr_cnt_d = addr_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (req_acc) begin
          cen_d = 1'b0;
          a_d   = req_addr;
          if (req_wr) begin
            gwen_d = 1'b0;
            wen_d  = DATA_WIDTH'(be_to_wen(WEN_MAX_BYTES'(req_be)));
            d_d    = req_wdata;
          end else begin
            d_d    = '0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    credit_d    = credit_q + CRD_W'(rd_acc) - CRD_W'(rsp_pop);
    req_rdy_d   = (state_d == ST_RUN) && (credit_d < CRD_W'(RSP_DEPTH));
    init_done_d = (state_d == ST_RUN);
  end

  // Registered pins, counters and the issue/capture read-tag pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_cnt_q  <= '0;
      credit_q    <= '0;
      cen_q       <= 1'b1;
      gwen_q      <= 1'b1;
      wen_q       <= '1;
      a_q         <= '0;
      d_q         <= '0;
      req_rdy_q   <= 1'b0;
      init_done_q <= 1'b0;
      iss_vld_q   <= 1'b0;
      cap_vld_q   <= 1'b0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      credit_q    <= credit_d;
      cen_q       <= cen_d;
      gwen_q      <= gwen_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
      req_rdy_q   <= req_rdy_d;
      init_done_q <= init_done_d;
      iss_vld_q   <= rd_acc;
      cap_vld_q   <= iss_vld_q;
    end
  end

  aq_f_spsram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (cap_vld_q),
    .din   (Q),
    .pop   (rsp_pop),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (rsp_rdata)
  );

  // Outstanding credits always cover what already sits in the FIFO.
  a_credit_covers_fifo: assert property (@(posedge CLK) disable iff (RST)
    credit_q >= fifo_count);

  assign init_done = init_done_q;
  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = !fifo_empty;
  assign A         = a_q;
  assign CEN       = cen_q;
  assign GWEN      = gwen_q;
  assign WEN       = wen_q;
  assign D         = d_q;

endmodule

// File: tb/tb_aq_f_spsram_2048x32_ctrl.sv
// Bench for aq_f_spsram_2048x32_ctrl: behavioural SRAM on the pins, a word-level
// memory model plus expected-response queue, scenario tasks run in sequence.
module tb_aq_f_spsram_2048x32_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int NW = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          init_done, req_rdy, rsp_vld;
  logic          req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic [DW-1:0] rsp_rdata, WEN, D, Q;
  logic [AW-1:0] A;
  logic          CEN, GWEN;

  aq_f_spsram_2048x32_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .INIT_EN (1'b1), .INIT_VAL ('0), .RSP_DEPTH (4)
  ) dut (
    .CLK (CLK), .RST (RST), .init_done (init_done),
    .req_vld (req_vld), .req_rdy (req_rdy), .req_wr (req_wr), .req_addr (req_addr),
    .req_wdata (req_wdata), .req_be (req_be),
    .rsp_vld (rsp_vld), .rsp_rdy (rsp_rdy), .rsp_rdata (rsp_rdata),
    .A (A), .CEN (CEN), .GWEN (GWEN), .WEN (WEN), .D (D), .Q (Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM; contents scrambled while reset is held.
  logic [DW-1:0] sram [NW];
  logic [DW-1:0] q_r = '0;
  assign Q = q_r;
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NW; i++) sram[i] <= $urandom;
    end else if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       q_r <= sram[A];
    end
  end

  // Reference model: word memory and expected read data in accept order.
  logic [DW-1:0] exp_mem [NW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int n_chk = 0, n_pass = 0, n_cen = 0;
  logic s_acc, s_rsp_vld, s_cen, s_gwen, s_rdy, s_rrdy;
  logic [DW-1:0] s_wen, s_d, s_rdata;
  logic [AW-1:0] s_a;

  // One clock: sample the current cycle at the falling edge, then cross the rising edge.
  task automatic step();
    @(negedge CLK);
    s_acc = req_vld && req_rdy;
    s_rsp_vld = rsp_vld; s_rdata = rsp_rdata; s_rdy = req_rdy; s_rrdy = rsp_rdy;
    s_cen = CEN; s_gwen = GWEN; s_wen = WEN; s_a = A; s_d = D;
    if (!CEN) n_cen++;
    if (s_acc) begin
      if (req_wr) begin
        for (int b = 0; b < BW; b++)
          if (req_be[b]) exp_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        exp_q.push_back(exp_mem[req_addr]);
      end
    end
    if (rsp_vld && rsp_rdy) got_q.push_back(rsp_rdata);
    @(posedge CLK); #1;
  endtask

  // Idle with rsp_rdy high until every expected response arrived, then a few extra cycles.
  task automatic drain(output bit timed_out);
    req_vld = 1'b0; rsp_rdy = 1'b1; timed_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (got_q.size() >= exp_q.size()) begin timed_out = 1'b0; break; end
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if ({CEN, GWEN, WEN, A, D} !== {1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}})
      $display("FAIL reset_pins: got CEN=%b GWEN=%b WEN=%h A=%h D=%h want 1 1 ffffffff 0 0", CEN, GWEN, WEN, A, D);
    else n_pass++;
    n_chk++;
    if ({req_rdy, rsp_vld, init_done, rsp_rdata} !== {3'b000, {DW{1'b0}}})
      $display("FAIL reset_hs: got rdy=%b vld=%b done=%b rdata=%h want 0 0 0 0", req_rdy, rsp_vld, init_done, rsp_rdata);
    else n_pass++;
    RST = 1'b0;
  endtask

  // Must start #1 after a reset edge with RST just released.
  task automatic test_init_sweep(input string tag);
    int nwr = 0, bad = 0, early = 0, stale = 0, nz = 0;
    for (int c = 1; c <= NW; c++) begin
      @(posedge CLK); #1;
      if (!CEN && !GWEN && WEN == '0 && D == '0) nwr++;
      if (CEN || A != AW'(c - 1)) bad++;
      if (init_done || req_rdy) early++;
      if (rsp_vld) stale++;
    end
    @(posedge CLK); #1;
    n_chk++; if (nwr != NW) $display("FAIL %s_writes: got %0d want %0d", tag, nwr, NW); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL %s_addr_seq: got %0d bad cycles want 0", tag, bad); else n_pass++;
    n_chk++; if (early != 0) $display("FAIL %s_early_done: got %0d want 0", tag, early); else n_pass++;
    n_chk++; if (stale != 0) $display("FAIL %s_stale_rsp: got %0d want 0", tag, stale); else n_pass++;
    n_chk++;
    if ({init_done, req_rdy, CEN} !== 3'b111)
      $display("FAIL %s_done_2049: got done=%b rdy=%b cen=%b want 1 1 1", tag, init_done, req_rdy, CEN);
    else n_pass++;
    for (int i = 0; i < NW; i++) if (sram[i] != '0) nz++;
    n_chk++; if (nz != 0) $display("FAIL %s_zero_fill: got %0d nonzero words want 0", tag, nz); else n_pass++;
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
  endtask

  task automatic test_read_after_init();
    int lat = 0;
    bit to;
    logic [DW-1:0] g;
    logic [3:0] pins_ok = 4'b0;
    rsp_rdy = 1'b1; req_vld = 1'b1; req_wr = 1'b0;
    req_addr = AW'($urandom_range(16, NW - 1));
    step();
    n_chk++; if (s_acc !== 1'b1) $display("FAIL rd0_accept: got %b want 1", s_acc); else n_pass++;
    req_vld = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) pins_ok = {s_cen == 1'b0, s_gwen == 1'b1, s_wen == '1, s_a == req_addr && s_d == '0};
      if (s_rsp_vld && lat == 0) lat = n;
    end
    n_chk++; if (pins_ok !== 4'hF) $display("FAIL rd0_pins: got ok=%b want 1111", pins_ok); else n_pass++;
    n_chk++; if (lat != 3) $display("FAIL rd0_latency: got %0d want 3", lat); else n_pass++;
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1) $display("FAIL rd0_count: got %0d want 1", got_q.size());
    else begin
      g = got_q.pop_front();
      if (g !== 32'h0) $display("FAIL rd0_data: got %h want 00000000", g); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_mask();
    bit to;
    logic [DW-1:0] g, e;
    rsp_rdy = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 11'd5;
    req_wdata = 32'hDEADBEEF; req_be = 4'b0101;
    step();
    n_chk++; if (s_acc !== 1'b1) $display("FAIL wm_accept: got %b want 1", s_acc); else n_pass++;
    req_vld = 1'b0;
    step();
    n_chk++;
    if ({s_cen, s_gwen, s_wen, s_a, s_d} !== {1'b0, 1'b0, 32'hFF00FF00, 11'd5, 32'hDEADBEEF})
      $display("FAIL wm_pins: got CEN=%b GWEN=%b WEN=%h A=%h D=%h want 0 0 ff00ff00 5 deadbeef", s_cen, s_gwen, s_wen, s_a, s_d);
    else n_pass++;
    req_vld = 1'b1; req_wr = 1'b0;
    step();
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1) $display("FAIL wm_count: got %0d want 1", got_q.size());
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== 32'h00AD00EF || g !== e) $display("FAIL wm_data: got %h want 00ad00ef", g); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int nacc = 0, run = 0, maxrun = 0;
    bit to;
    logic [DW-1:0] g, e;
    rsp_rdy = 1'b1; req_wr = 1'b1; req_be = '1;
    for (int i = 0; i < 8; i++) begin
      req_vld = 1'b1; req_addr = AW'(i); req_wdata = $urandom;
      step();
    end
    req_vld = 1'b0;
    repeat (4) step();
    req_vld = 1'b1; req_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) req_addr = AW'(i); else req_vld = 1'b0;
      step();
      if (s_acc) nacc++;
      if (s_rsp_vld) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    n_chk++; if (nacc != 8) $display("FAIL b2b_accepts: got %0d want 8", nacc); else n_pass++;
    n_chk++; if (maxrun != 8) $display("FAIL b2b_vld_run: got %0d want 8", maxrun); else n_pass++;
    drain(to);
    n_chk++; if (to || got_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL b2b_data: got %h want %h", g, e); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int nacc = 0, unstable = 0;
    bit to, seen = 1'b0;
    logic [DW-1:0] first_d = '0, g, e;
    rsp_rdy = 1'b0; req_vld = 1'b1; req_wr = 1'b0; n_cen = 0;
    for (int i = 0; i < 10; i++) begin
      req_addr = AW'($urandom_range(0, 7));
      step();
      if (s_acc) nacc++;
      if (s_rsp_vld && !seen) begin seen = 1'b1; first_d = s_rdata; end
      else if (seen && (!s_rsp_vld || s_rdata !== first_d)) unstable++;
    end
    n_chk++; if (nacc != 4) $display("FAIL bp_accepts: got %0d want 4", nacc); else n_pass++;
    n_chk++; if (n_cen != 4) $display("FAIL bp_cen_cycles: got %0d want 4", n_cen); else n_pass++;
    n_chk++; if (s_rdy !== 1'b0) $display("FAIL bp_rdy_low: got %b want 0", s_rdy); else n_pass++;
    n_chk++; if (!seen || unstable != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    step();
    n_chk++; if (s_rdy !== 1'b1 || s_acc !== 1'b1) $display("FAIL bp_reopen: got rdy=%b acc=%b want 1 1", s_rdy, s_acc); else n_pass++;
    repeat (3) step();
    drain(to);
    n_chk++; if (to || got_q.size() != 5) $display("FAIL bp_count: got %0d want 5", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL bp_data: got %h want %h", g, e); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_then_read();
    bit to;
    logic [DW-1:0] g;
    rsp_rdy = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 11'd9;
    req_wdata = 32'h12345678; req_be = '1;
    step();
    req_wr = 1'b0;
    step();
    n_chk++; if (s_acc !== 1'b1) $display("FAIL wr_rd_accept: got %b want 1", s_acc); else n_pass++;
    drain(to);
    n_chk++;
    if (to || got_q.size() != 1) $display("FAIL wr_rd_count: got %0d want 1", got_q.size());
    else begin
      g = got_q.pop_front();
      if (g !== 32'h12345678) $display("FAIL wr_rd_data: got %h want 12345678", g); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_mix();
    int unstable = 0;
    bit to, hold = 1'b0;
    logic [DW-1:0] hold_d = '0, g, e;
    for (int i = 0; i < 400; i++) begin
      req_vld = ($urandom_range(0, 3) != 0); req_wr = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom_range(0, 15)); req_wdata = $urandom; req_be = BW'($urandom);
      rsp_rdy = ($urandom_range(0, 2) != 0);
      step();
      if (hold && (!s_rsp_vld || s_rdata !== hold_d)) unstable++;
      hold = s_rsp_vld && !s_rrdy; hold_d = s_rdata;
    end
    n_chk++; if (unstable != 0) $display("FAIL rnd_stable: got %0d unstable cycles want 0", unstable); else n_pass++;
    drain(to);
    n_chk++;
    if (to || got_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (g !== e) $display("FAIL rnd_data: got %h want %h", g, e); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_op();
    int nacc = 0, lat = 0;
    bit to;
    logic [DW-1:0] g;
    rsp_rdy = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = 11'd3;
    step();
    req_vld = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin step(); if (s_rsp_vld) lat = n; end
    n_chk++; if (lat == 0) $display("FAIL rst_pending: got no response want one pending"); else n_pass++;
    req_vld = 1'b1; req_addr = 11'd4; step();
    req_addr = 11'd5; step();
    req_vld = 1'b0; RST = 1'b1;
    step();
    n_chk++;
    if ({rsp_vld, CEN, req_rdy, init_done} !== 4'b0100)
      $display("FAIL rst_mid_state: got vld=%b cen=%b rdy=%b done=%b want 0 1 0 0", rsp_vld, CEN, req_rdy, init_done);
    else n_pass++;
    RST = 1'b0;
    got_q.delete(); exp_q.delete();
    test_init_sweep("sweep2");
    req_vld = 1'b1; req_addr = AW'($urandom_range(0, NW - 1));
    for (int i = 0; i < 8; i++) begin step(); if (s_acc) nacc++; end
    n_chk++; if (nacc != 4) $display("FAIL rst_credit: got %0d accepts want 4", nacc); else n_pass++;
    drain(to);
    n_chk++; if (to || got_q.size() != 4) $display("FAIL rst_count: got %0d want 4", got_q.size()); else n_pass++;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      n_chk++; if (g !== 32'h0) $display("FAIL rst_data: got %h want 00000000", g); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_init_sweep("init");
    test_read_after_init();
    test_write_mask();
    test_back_to_back();
    test_backpressure();
    test_write_then_read();
    test_random_mix();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
